// File: rtl/sram_spi_pkg.sv
// Shared constants, state encoding and byte-ordering helpers for the serial SRAM master.
package sram_spi_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } sram_spi_state_t;

  // Index of the final bit of a transaction: 32 header bits plus 8 per data byte.
  function automatic logic [6:0] last_bit_idx(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 7'd39;
      SIZE_HALF: return 7'd47;
      SIZE_WORD: return 7'd63;
      default:   return 7'd63;
    endcase
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // The receive shifter holds the first byte highest; reorder so byte k lands at bits 8k+7:8k.
  function automatic logic [31:0] assemble_read(input logic [31:0] rx, input logic [1:0] size);
    case (size)
      SIZE_BYTE: return {24'h0, rx[7:0]};
      SIZE_HALF: return {16'h0, rx[7:0], rx[15:8]};
      default:   return byte_swap(rx);
    endcase
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// SCLK half-period timer: sclk phase, low-half start strobe (fall_tick) and the
// last-cycle-of-high-half strobe (sample_tick). The half-period is latched on load.
module spi_tick_gen #(
  parameter int SLOW_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic slow,
  input  logic run,
  output logic sclk,
  output logic fall_tick,
  output logic sample_tick
);

  localparam int CW = $clog2(SLOW_DIV);
  localparam logic [CW-1:0] SLOW_M1 = CW'(SLOW_DIV - 1);

  logic [CW-1:0] half_m1;
  logic [CW-1:0] cnt;
  logic          phase;

  assign sclk        = phase;
  assign sample_tick = run && phase && (cnt == '0);
  assign fall_tick   = load || sample_tick;

  // Load restarts a low half; idling forces the clock low so it is never high with CE released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_m1 <= '0;
      cnt     <= '0;
      phase   <= 1'b0;
    end else if (load) begin
      half_m1 <= slow ? SLOW_M1 : '0;
      cnt     <= slow ? SLOW_M1 : '0;
      phase   <= 1'b0;
    end else if (!run) begin
      phase <= 1'b0;
    end else if (cnt == '0) begin
      cnt   <= half_m1;
      phase <= ~phase;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/sram_spi.sv
// SPI master for a 23LC1024-class SRAM: one sequential READ/WRITE transaction per request,
// moving 1, 2 or 4 bytes little-endian and pulsing valid on completion.
module sram_spi
  import sram_spi_pkg::*;
#(
  parameter int SLOW_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  input  logic        slow_mode,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        valid,
  input  logic        so,
  output logic        si,
  output logic        sclk,
  output logic        sram_ce
);

  sram_spi_state_t state_q, state_d;

  logic        write_q;
  logic [1:0]  size_q;
  logic [31:0] ca_q;
  logic [31:0] data_q;
  logic [6:0]  bit_cnt_q;
  logic        accept;
  logic        running;
  logic        last_bit;
  logic        fall_tick;
  logic        sample_tick;
  logic        si_d;

  assign accept   = (state_q == IDLE) && start;
  assign running  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
  assign last_bit = (bit_cnt_q == last_bit_idx(size_q));

  spi_tick_gen #(
    .SLOW_DIV(SLOW_DIV)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .slow       (slow_mode),
    .run        (running),
    .sclk       (sclk),
    .fall_tick  (fall_tick),
    .sample_tick(sample_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CMD;
      CMD:  if (sample_tick && bit_cnt_q == 7'd7) state_d = ADDR;
      ADDR: if (sample_tick && bit_cnt_q == 7'd31) state_d = DATA;
      DATA: if (sample_tick && last_bit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = running;
    sram_ce = !running;
    valid   = (state_q == DONE);
  end

  // Next MOSI bit, presented at the start of each low half; reads keep MOSI low during data.
  always_comb begin
    si_d = 1'b0;
    case (state_q)
      IDLE:      si_d = write ? SPI_CMD_WRITE[7] : SPI_CMD_READ[7];
      CMD, ADDR: si_d = (bit_cnt_q == 7'd31) ? (write_q & data_q[31]) : ca_q[30];
      DATA:      si_d = write_q & ~last_bit & data_q[30];
      default:   si_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q   <= 1'b0;
      size_q    <= 2'b00;
      ca_q      <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      rdata     <= '0;
      si        <= 1'b0;
    end else begin
      if (fall_tick) si <= si_d;
      if (accept) begin
        write_q   <= write;
        size_q    <= size;
        ca_q      <= {(write ? SPI_CMD_WRITE : SPI_CMD_READ), addr};
        data_q    <= byte_swap(wdata);
        bit_cnt_q <= '0;
      end else if (sample_tick) begin
        bit_cnt_q <= bit_cnt_q + 7'd1;
        if (state_q != DATA) begin
          ca_q <= {ca_q[30:0], 1'b0};
        end else begin
          data_q <= {data_q[30:0], so};
          if (!write_q && last_bit) rdata <= assemble_read({data_q[30:0], so}, size_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_spi.sv
// Bench for sram_spi: a behavioural SPI SRAM plus a cycle-level transaction model of the
// master's pins, compared every cycle, with hand-computed latency and data expectations.
module tb_sram_spi;

  localparam int SLOW_DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [23:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        slow_mode = 1'b0;
  logic        so = 1'b0;
  logic [31:0] rdata;
  logic        busy;
  logic        valid;
  logic        si;
  logic        sclk;
  logic        sram_ce;

  int total = 0;
  int bad = 0;

  sram_spi #(.SLOW_DIV(SLOW_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .write    (write),
    .size     (size),
    .addr     (addr),
    .wdata    (wdata),
    .slow_mode(slow_mode),
    .rdata    (rdata),
    .busy     (busy),
    .valid    (valid),
    .so       (so),
    .si       (si),
    .sclk     (sclk),
    .sram_ce  (sram_ce)
  );

  initial forever #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Behavioural SPI SRAM: samples MOSI on rising sclk, drives MISO after falling sclk.
  bit [7:0]    sram_mem [int];
  int          s_bits = 0;
  logic [7:0]  s_cmd = '0;
  logic [23:0] s_addr = '0;
  logic [7:0]  s_byte = '0;
  logic [7:0]  log_cmd = '0;
  logic [23:0] log_addr = '0;
  logic [7:0]  log_bytes [$];
  int          log_count = 0;

  initial forever begin
    @(posedge sclk);
    if (!sram_ce) begin
      if (s_bits < 8) s_cmd = {s_cmd[6:0], si};
      else if (s_bits < 32) s_addr = {s_addr[22:0], si};
      else if (s_cmd == 8'h02) begin
        s_byte = {s_byte[6:0], si};
        if ((s_bits - 32) % 8 == 7) begin
          sram_mem[int'(s_addr) + (s_bits - 32) / 8] = s_byte;
          log_bytes.push_back(s_byte);
        end
      end else if (s_cmd == 8'h03) begin
        check_output("read_si_low", 64'(si), 64'(0));
      end
      s_bits++;
      if (s_bits == 32) begin
        log_cmd = s_cmd;
        log_addr = s_addr;
        log_count++;
        log_bytes.delete();
      end
    end
  end

  initial forever begin
    int idx;
    int key;
    logic [7:0] b;
    @(negedge sclk);
    if (!sram_ce && s_cmd == 8'h03 && s_bits >= 32) begin
      idx = s_bits - 32;
      key = int'(s_addr) + idx / 8;
      b = sram_mem.exists(key) ? sram_mem[key] : 8'h00;
      so = b[7 - idx % 8];
    end else begin
      so = 1'($urandom);
    end
  end

  initial forever begin
    @(posedge sram_ce or negedge reset);
    s_bits = 0;
  end

  // Transaction-level model of the pins: a transaction occupies 2*H*B cycles after accept,
  // followed by a single DONE cycle; memory contents are tracked per completed request.
  bit [7:0]    ref_mem [int];
  logic        m_active = 1'b0;
  int          m_t = 0;
  int          m_h = 1;
  int          m_b = 0;
  logic        m_write = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic [23:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  int          valid_count = 0;

  function automatic logic [7:0] ref_rd(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : 8'h00;
  endfunction

  task automatic model_done();
    if (m_write) begin
      for (int k = 0; k < n_bytes(m_size); k++) ref_mem[int'(m_addr) + k] = m_wdata[8*k +: 8];
    end else begin
      m_rdata = '0;
      for (int k = 0; k < n_bytes(m_size); k++) m_rdata[8*k +: 8] = ref_rd(int'(m_addr) + k);
    end
  endtask

  initial forever begin
    logic e_ce, e_busy, e_valid, e_sclk;
    @(posedge clk);
    if (!reset) begin
      m_active = 1'b0;
      m_rdata = '0;
    end else if (m_active) begin
      if (m_t == 2 * m_h * m_b + 1) m_active = 1'b0;
      else begin
        m_t++;
        if (m_t == 2 * m_h * m_b + 1) model_done();
      end
    end else if (start) begin
      m_active = 1'b1;
      m_t = 1;
      m_write = write;
      m_size = size;
      m_addr = addr;
      m_wdata = wdata;
      m_h = slow_mode ? SLOW_DIV : 1;
      m_b = 32 + 8 * n_bytes(size);
    end
    #1;
    if (m_active && m_t <= 2 * m_h * m_b) begin
      e_ce = 1'b0; e_busy = 1'b1; e_valid = 1'b0; e_sclk = 1'(((m_t - 1) / m_h) % 2);
    end else if (m_active) begin
      e_ce = 1'b1; e_busy = 1'b0; e_valid = 1'b1; e_sclk = 1'b0;
    end else begin
      e_ce = 1'b1; e_busy = 1'b0; e_valid = 1'b0; e_sclk = 1'b0;
    end
    check_output("cycle_ce_busy_valid_sclk_rdata", 64'({sram_ce, busy, valid, sclk, rdata}),
                 64'({e_ce, e_busy, e_valid, e_sclk, m_rdata}));
    if (valid) valid_count++;
  end

  task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic [23:0] a,
                                input logic [31:0] wd, input logic slow, input int exp_lat,
                                input logic [31:0] exp_rdata, input bit toggle_slow,
                                input bit poke_start);
    int lat, ce_low, rise1, rise2;
    logic prev_sclk;
    @(negedge clk);
    start = 1'b1; write = w; size = sz; addr = a; wdata = wd; slow_mode = slow;
    @(negedge clk);
    start = 1'b0; write = 1'($urandom); size = 2'($urandom); addr = 24'($urandom); wdata = $urandom;
    lat = -1; ce_low = 0; rise1 = -1; rise2 = -1; prev_sclk = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      if (!sram_ce) ce_low++;
      if (sclk && !prev_sclk) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev_sclk = sclk;
      if (valid) begin
        lat = i;
        break;
      end
      if (toggle_slow && i % 37 == 0) slow_mode = ~slow_mode;
      start = poke_start && (i == 20 || i == 60);
      if (start) begin
        write = 1'($urandom); size = 2'($urandom); addr = 24'($urandom); wdata = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_output("latency", 64'(lat), 64'(exp_lat));
    check_output("ce_low_cycles", 64'(ce_low), 64'(exp_lat - 1));
    check_output("sclk_period", 64'(rise2 - rise1), 64'(slow ? 2 * SLOW_DIV : 2));
    check_output("logged_cmd", 64'(log_cmd), 64'(w ? 8'h02 : 8'h03));
    check_output("logged_addr", 64'(log_addr), 64'(a));
    if (w) begin
      check_output("logged_byte_count", 64'(log_bytes.size()), 64'(n_bytes(sz)));
      for (int k = 0; k < n_bytes(sz) && k < log_bytes.size(); k++)
        check_output("logged_write_byte", 64'(log_bytes[k]), 64'(wd[8*k +: 8]));
    end else begin
      check_output("rdata", 64'(rdata), 64'(exp_rdata));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int vc, lc;
    repeat (3) @(negedge clk);
    check_output("reset_ce", 64'(sram_ce), 64'(1));
    check_output("reset_sclk", 64'(sclk), 64'(0));
    check_output("reset_si", 64'(si), 64'(0));
    check_output("reset_busy", 64'(busy), 64'(0));
    check_output("reset_valid", 64'(valid), 64'(0));
    check_output("reset_rdata", 64'(rdata), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] fast word write / read");
    apply_stimulus(1'b1, 2'b10, 24'h012345, 32'hDEADBEEF, 1'b0, 129, 32'h0, 1'b0, 1'b0);
    check_output("write_byte0_literal", 64'(log_bytes.size() > 0 ? log_bytes[0] : 8'h00), 64'(8'hEF));
    check_output("write_byte3_literal", 64'(log_bytes.size() > 3 ? log_bytes[3] : 8'h00), 64'(8'hDE));
    apply_stimulus(1'b0, 2'b10, 24'h012345, 32'h0, 1'b0, 129, 32'hDEADBEEF, 1'b0, 1'b0);

    $display("[TB] byte and half reads");
    apply_stimulus(1'b0, 2'b00, 24'h012346, 32'h0, 1'b0, 81, 32'h000000BE, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b00, 24'h012347, 32'h0, 1'b0, 81, 32'h000000AD, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b01, 24'h012345, 32'h0, 1'b0, 97, 32'h0000BEEF, 1'b0, 1'b0);

    $display("[TB] half write, partial-word readback, size 11");
    apply_stimulus(1'b1, 2'b01, 24'h000200, 32'hCAFE1234, 1'b0, 97, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b10, 24'h000200, 32'h0, 1'b0, 129, 32'h00001234, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b11, 24'h012345, 32'h0, 1'b0, 129, 32'hDEADBEEF, 1'b0, 1'b0);

    $display("[TB] slow word read with slow_mode toggling");
    apply_stimulus(1'b0, 2'b10, 24'h012345, 32'h0, 1'b1, 1025, 32'hDEADBEEF, 1'b1, 1'b0);

    $display("[TB] start pulsed while busy");
    vc = valid_count;
    lc = log_count;
    apply_stimulus(1'b1, 2'b10, 24'h000300, 32'h0BADF00D, 1'b0, 129, 32'h0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_output("busy_start_valid_count", 64'(valid_count - vc), 64'(1));
    check_output("busy_start_cmd_count", 64'(log_count - lc), 64'(1));

    $display("[TB] reset mid-transaction");
    vc = valid_count;
    lc = log_count;
    @(negedge clk);
    start = 1'b1; write = 1'b1; size = 2'b10; addr = 24'h000400; wdata = 32'h55AA55AA; slow_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    check_output("abort_busy_before", 64'(busy), 64'(1));
    #2 reset = 1'b0;
    #1;
    check_output("abort_ce", 64'(sram_ce), 64'(1));
    check_output("abort_sclk", 64'(sclk), 64'(0));
    check_output("abort_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_output("abort_no_valid", 64'(valid_count - vc), 64'(0));
    check_output("abort_no_cmd", 64'(log_count - lc), 64'(0));
    apply_stimulus(1'b1, 2'b10, 24'h000400, 32'h55AA55AA, 1'b0, 129, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b10, 24'h000400, 32'h0, 1'b0, 129, 32'h55AA55AA, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
